// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, memory results queue in a FIFO.
// Define WB_MEM_BYPASS_EN to let a memory result skip an empty FIFO when the ALU is idle.
module wb_arbiter #(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADD_WIDTH-1:0]          alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          issue_valid,
    input  logic [ADD_WIDTH-1:0]          issue_rd,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADD_WIDTH-1:0]          mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic [ADD_WIDTH-1:0]          AD3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic                          WE3,
    output logic [2**ADD_WIDTH-1:0]       busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADD_WIDTH;

    logic [ADD_WIDTH-1:0]  fifoRd_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifoData_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADD_WIDTH-1:0]  ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
    logic                  we3_q, we3_d;
    logic                  memSrc_q, memSrc_d;
    logic [NREG-1:0]       busy_q, busy_d;

    logic                  fifoEmpty, fifoFull, memHs, bypass, push, pop;
    logic                  selValid, selMem;
    logic [ADD_WIDTH-1:0]  selRd;
    logic [DATA_WIDTH-1:0] selData;

    always_comb begin
        fifoEmpty = (count_q == '0);
        fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
        mem_ready = !fifoFull && !rst;
        memHs     = mem_valid && mem_ready;
        bypass    = 1'b0;
`ifdef WB_MEM_BYPASS_EN
        bypass    = memHs && fifoEmpty && !alu_valid;
`endif
        push      = memHs && !bypass;
        pop       = !alu_valid && !fifoEmpty;

        selValid  = 1'b0;
        selMem    = 1'b0;
        selRd     = '0;
        selData   = '0;
        if (alu_valid) begin
            selValid = 1'b1;
            selRd    = alu_rd;
            selData  = alu_result;
        end else if (pop) begin
            selValid = 1'b1;
            selMem   = 1'b1;
            selRd    = fifoRd_q[rdPtr_q];
            selData  = fifoData_q[rdPtr_q];
        end else if (bypass) begin
            selValid = 1'b1;
            selMem   = 1'b1;
            selRd    = mem_rd;
            selData  = mem_data;
        end

        // Writes to x0 still consume their source but never assert the write enable.
        we3_d    = selValid && (selRd != '0);
        ad3_d    = selRd;
        wd3_d    = selData;
        memSrc_d = selMem && we3_d;

        wrPtr_d  = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d  = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Clear lands when the register file captures the memory write; a new issue overrides it.
        busy_d = busy_q;
        if (we3_q && memSrc_q)
            busy_d[ad3_q] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            ad3_q    <= '0;
            wd3_q    <= '0;
            we3_q    <= 1'b0;
            memSrc_q <= 1'b0;
            busy_q   <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            ad3_q    <= ad3_d;
            wd3_q    <= wd3_d;
            we3_q    <= we3_d;
            memSrc_q <= memSrc_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifoRd_q[wrPtr_q]   <= mem_rd;
            fifoData_q[wrPtr_q] <= mem_data;
        end
    end

    assign AD3        = ad3_q;
    assign WD3        = wd3_q;
    assign WE3        = we3_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;

   localparam int FIFO_DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_result;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic [4:0]  AD3;
   logic [31:0] WD3;
   logic        WE3;
   logic [31:0] busy;
   logic [2:0]  fifo_count;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } memEntry_t;

   // Reference model state: pending memory results in arrival order plus the expected write stage.
   memEntry_t   memQ[$];
   logic        expWE;
   logic        expFromMem;
   logic [4:0]  expAD;
   logic [31:0] expWD;
   logic [31:0] expBusy;

   wb_arbiter #(
      .ADD_WIDTH(5),
      .DATA_WIDTH(32),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .alu_valid(alu_valid),
      .alu_rd(alu_rd),
      .alu_result(alu_result),
      .issue_valid(issue_valid),
      .issue_rd(issue_rd),
      .mem_valid(mem_valid),
      .mem_ready(mem_ready),
      .mem_rd(mem_rd),
      .mem_data(mem_data),
      .AD3(AD3),
      .WD3(WD3),
      .WE3(WE3),
      .busy(busy),
      .fifo_count(fifo_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advances the reference model across one clock edge using this cycle's inputs.
   task automatic modelStep(input logic rstIn, input logic aluV, input logic [4:0] aluRd,
                            input logic [31:0] aluRes, input logic issV, input logic [4:0] issRd,
                            input logic memV, input logic [4:0] memRdIn, input logic [31:0] memDataIn);
      logic        hs;
      logic        clearValid;
      logic [4:0]  clearRd;
      logic        selV;
      logic        selMem;
      logic [4:0]  selRd;
      logic [31:0] selData;
      memEntry_t   e;
      if (rstIn) begin
         memQ.delete();
         expWE      = 1'b0;
         expFromMem = 1'b0;
         expAD      = '0;
         expWD      = '0;
         expBusy    = '0;
         return;
      end
      hs         = memV && (memQ.size() < FIFO_DEPTH);
      clearValid = expWE && expFromMem;
      clearRd    = expAD;
      selV       = 1'b0;
      selMem     = 1'b0;
      selRd      = '0;
      selData    = '0;
      if (aluV) begin
         selV    = 1'b1;
         selRd   = aluRd;
         selData = aluRes;
      end else if (memQ.size() > 0) begin
         e       = memQ.pop_front();
         selV    = 1'b1;
         selMem  = 1'b1;
         selRd   = e.rd;
         selData = e.data;
      end
`ifdef WB_MEM_BYPASS_EN
      else if (hs) begin
         selV    = 1'b1;
         selMem  = 1'b1;
         selRd   = memRdIn;
         selData = memDataIn;
         hs      = 1'b0;
      end
`endif
      if (hs) begin
         e.rd   = memRdIn;
         e.data = memDataIn;
         memQ.push_back(e);
      end
      expWE      = selV && (selRd != 5'd0);
      expFromMem = selMem;
      expAD      = selRd;
      expWD      = selData;
      if (clearValid)
         expBusy[clearRd] = 1'b0;
      if (issV && (issRd != 5'd0))
         expBusy[issRd] = 1'b1;
   endtask

   // Drives one cycle of inputs, checks the handshake signal, steps the model and
   // checks the registered outputs just after the edge.
   task automatic applyStimulus(input logic rstIn, input logic aluV, input logic [4:0] aluRd,
                                input logic [31:0] aluRes, input logic issV, input logic [4:0] issRd,
                                input logic memV, input logic [4:0] memRdIn, input logic [31:0] memDataIn);
      @(negedge clk);
      rst         = rstIn;
      alu_valid   = aluV;
      alu_rd      = aluRd;
      alu_result  = aluRes;
      issue_valid = issV;
      issue_rd    = issRd;
      mem_valid   = memV;
      mem_rd      = memRdIn;
      mem_data    = memDataIn;
      #1;
      checkOutput("mem_ready", 64'(mem_ready), 64'(!rstIn && (memQ.size() < FIFO_DEPTH)));
      modelStep(rstIn, aluV, aluRd, aluRes, issV, issRd, memV, memRdIn, memDataIn);
      @(posedge clk);
      #1;
      checkOutput("WE3", 64'(WE3), 64'(expWE));
      checkOutput("fifo_count", 64'(fifo_count), 64'(memQ.size()));
      checkOutput("busy", 64'(busy), 64'(expBusy));
      if (expWE) begin
         checkOutput("AD3", 64'(AD3), 64'(expAD));
         checkOutput("WD3", 64'(WD3), 64'(expWD));
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++)
         applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Main sequence: directed scenarios first, then randomized traffic with occasional resets.
   initial begin
      logic        rR, aV, iV, mV;
      logic [4:0]  aRd, iRd, mRd;
      logic [31:0] aRes, mData;

      rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
      issue_valid = 1'b0; issue_rd = '0; mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      memQ.delete(); expWE = 1'b0; expFromMem = 1'b0; expAD = '0; expWD = '0; expBusy = '0;

      // Reset held with ALU traffic present must still leave everything idle.
      applyStimulus(1'b1, 1'b1, 5'd4, 32'h55, 1'b1, 5'd6, 1'b1, 5'd2, 32'h66);
      applyStimulus(1'b1, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("rstWE3", 64'(WE3), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstReady", 64'(mem_ready), 64'd0);
      idleCycles(1);
      checkOutput("postRstReady", 64'(mem_ready), 64'd1);

      // Plain ALU write, then idle.
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("aluAD3", 64'(AD3), 64'd5);
      checkOutput("aluWD3", 64'(WD3), 64'hDEADBEEF);
      checkOutput("aluWE3", 64'(WE3), 64'd1);
      idleCycles(1);
      checkOutput("aluIdleWE3", 64'(WE3), 64'd0);

      // Writes to x0 from both sources are dropped.
      applyStimulus(1'b0, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("x0AluWE3", 64'(WE3), 64'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h77);
      idleCycles(3);
      checkOutput("x0MemCount", 64'(fifo_count), 64'd0);

      // ALU priority over a queued memory result, with scoreboard tracking on rd 7.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
      checkOutput("busy7Set", 64'(busy[7]), 64'd1);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h30, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h31, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h32, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("prioAD3alu", 64'(AD3), 64'd3);
      idleCycles(1);
      checkOutput("prioAD3mem", 64'(AD3), 64'd7);
      checkOutput("prioWD3mem", 64'(WD3), 64'h1234);
      checkOutput("busy7Held", 64'(busy[7]), 64'd1);
      idleCycles(1);
      checkOutput("busy7Clear", 64'(busy[7]), 64'd0);

      // Fill the FIFO under continuous ALU traffic, then drain and wrap the pointers.
      for (int k = 1; k <= 4; k++)
         applyStimulus(1'b0, 1'b1, 5'd10, 32'(k), 1'b0, 5'd0, 1'b1, 5'(k), 32'h100 + 32'(k));
      checkOutput("fullCount", 64'(fifo_count), 64'd4);
      checkOutput("fullReady", 64'(mem_ready), 64'd0);
      applyStimulus(1'b0, 1'b1, 5'd11, 32'h9, 1'b0, 5'd0, 1'b1, 5'd20, 32'hBAD);
      idleCycles(4);
      applyStimulus(1'b0, 1'b1, 5'd12, 32'h1, 1'b0, 5'd0, 1'b1, 5'd21, 32'h201);
      applyStimulus(1'b0, 1'b1, 5'd12, 32'h2, 1'b0, 5'd0, 1'b1, 5'd22, 32'h202);
      idleCycles(3);

      // Memory result into an empty FIFO with the ALU idle.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'hA5);
`ifdef WB_MEM_BYPASS_EN
      checkOutput("bypWE3N1", 64'(WE3), 64'd1);
      checkOutput("bypCount", 64'(fifo_count), 64'd0);
`else
      checkOutput("bypWE3N1", 64'(WE3), 64'd0);
      checkOutput("bypCount", 64'(fifo_count), 64'd1);
`endif
      idleCycles(3);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         rR    = ($urandom_range(0, 59) == 0);
         aV    = ($urandom_range(0, 99) < 45);
         aRd   = 5'($urandom_range(0, 31));
         aRes  = $urandom;
         iV    = ($urandom_range(0, 99) < 30);
         iRd   = 5'($urandom_range(0, 31));
         mV    = ($urandom_range(0, 99) < 55);
         mRd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         mData = $urandom;
         applyStimulus(rR, aV, aRd, aRes, iV, iRd, mV, mRd, mData);
      end
      idleCycles(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
